// File: rtl/pad_cfg_ctrl_pkg.sv
// zerosoc_pad_pkg: shared definitions for the GPIO pad-ring configuration
// controller (pad_cfg_ctrl / pad_cfg_seq / pad_cfg_ctrl_if).
//   - ring geometry and timing constants
//   - bit offsets of the 16-bit per-pad config word
//   - power-on / update state enum
//   - side/slot helpers for a flat pad index
package zerosoc_pad_pkg;

    localparam int NumPads     = 36;
    localparam int PadsPerSide = 9;
    localparam int PadIdxW     = 6;
    localparam int CfgW        = 16;

    localparam int RampCycles  = 16;   // cycles per power-on step, >= 1
    localparam int HoldCycles  = 4;    // freeze time either side of a write, >= 1
    localparam logic [2:0] DefaultDm = 3'b110;

    // One counter serves both ramp and hold phases, so size it for the longer.
    localparam int CntW = $clog2(((RampCycles > HoldCycles) ? RampCycles : HoldCycles) + 1);

    // Per-pad config word layout
    localparam int BitHldHN      = 0;
    localparam int BitEnH        = 1;
    localparam int BitEnInpH     = 2;
    localparam int BitEnVddaH    = 3;
    localparam int BitEnVswitchH = 4;
    localparam int BitEnVddio    = 5;
    localparam int BitIbModeSel  = 6;
    localparam int BitVtripSel   = 7;
    localparam int BitSlow       = 8;
    localparam int BitHldOvr     = 9;
    localparam int BitAnalogEn   = 10;
    localparam int BitAnalogSel  = 11;
    localparam int BitAnalogPol  = 12;
    localparam int BitDmLo       = 13;   // dm occupies [15:13]

    typedef enum logic [2:0] {
        P_VDD, P_EN, P_INP, P_REL, RUN, U_HOLD, U_WR, U_REL
    } seq_state_e;

    // Side 0=west, 1=north, 2=east, 3=south. Only meaningful for p < NumPads.
    function automatic logic [1:0] pad_side(input logic [PadIdxW-1:0] p);
        return 2'(p / PadIdxW'(PadsPerSide));
    endfunction

    function automatic logic [3:0] pad_slot(input logic [PadIdxW-1:0] p);
        return 4'(p % PadIdxW'(PadsPerSide));
    endfunction

endpackage

// File: rtl/pad_cfg_ctrl_if.sv
// pad_cfg_ctrl_if: single-pad configuration update channel.
//   master drives: cfg_valid_i, cfg_pad_i, cfg_dm_i, cfg_slow_i, cfg_vtrip_i
//   slave drives : cfg_ready_o (accept when valid&ready), cfg_err_o (bad index pulse)
interface pad_cfg_ctrl_if;
    import zerosoc_pad_pkg::*;

    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [PadIdxW-1:0] cfg_pad_i;
    logic [2:0]         cfg_dm_i;
    logic               cfg_slow_i;
    logic               cfg_vtrip_i;
    logic               cfg_err_o;

    modport master (
        output cfg_valid_i, cfg_pad_i, cfg_dm_i, cfg_slow_i, cfg_vtrip_i,
        input  cfg_ready_o, cfg_err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_pad_i, cfg_dm_i, cfg_slow_i, cfg_vtrip_i,
        output cfg_ready_o, cfg_err_o
    );

endinterface

// File: rtl/pad_cfg_seq.sv
// pad_cfg_seq: shared power-on / update sequencer for the pad ring.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   cfg_valid_i/pad_i update request and target index
//   accept_o          handshake this cycle (valid & ready)
//   wr_o              the write cycle of an update (state U_WR)
//   rel_nx_o          next-cycle "hold released ring-wide"
//   hold_nx_o         next-cycle "a single pad is frozen"
//   tgt_nx_o          next-cycle frozen pad index
//   en_vdd_o, en_h_o, en_inp_o   registered global enables
//   cfg_ready_o, cfg_err_o, por_done_o   registered status
// The *_nx outputs let the top register per-pad hold bits in step with state.
module pad_cfg_seq
    import zerosoc_pad_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    input  logic [PadIdxW-1:0] cfg_pad_i,
    output logic               accept_o,
    output logic               wr_o,
    output logic               rel_nx_o,
    output logic               hold_nx_o,
    output logic [PadIdxW-1:0] tgt_nx_o,
    output logic               en_vdd_o,
    output logic               en_h_o,
    output logic               en_inp_o,
    output logic               cfg_ready_o,
    output logic               cfg_err_o,
    output logic               por_done_o
);

    seq_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PadIdxW-1:0] tgt_q, tgt_d;
    logic en_vdd_q, en_vdd_d, en_h_q, en_h_d, en_inp_q, en_inp_d;
    logic ready_q, ready_d, err_q, err_d, por_q, por_d;
    logic rel_d, hold_d, step_done, pad_ok;

    assign pad_ok    = cfg_pad_i < PadIdxW'(NumPads);
    assign accept_o  = cfg_valid_i & ready_q;
    assign step_done = cnt_q == ((state_q inside {P_VDD, P_EN, P_INP, P_REL})
                                 ? CntW'(RampCycles - 1) : CntW'(HoldCycles - 1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= P_VDD;
            cnt_q    <= '0;
            tgt_q    <= '0;
            en_vdd_q <= 1'b0;
            en_h_q   <= 1'b0;
            en_inp_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            por_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            en_vdd_q <= en_vdd_d;
            en_h_q   <= en_h_d;
            en_inp_q <= en_inp_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            por_q    <= por_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            P_VDD:   if (step_done) state_d = P_EN;
            P_EN:    if (step_done) state_d = P_INP;
            P_INP:   if (step_done) state_d = P_REL;
            P_REL:   if (step_done) state_d = RUN;
            RUN:     if (accept_o && pad_ok) state_d = U_HOLD;
            U_HOLD:  if (step_done) state_d = U_WR;
            U_WR:    state_d = U_REL;
            U_REL:   if (step_done) state_d = RUN;
            default: state_d = P_VDD;
        endcase
        // Counter idles at 0 in RUN and restarts on every state change.
        cnt_d = (state_d != state_q || state_q == RUN) ? '0 : cnt_q + CntW'(1);
    end

    // Outputs, computed from the next state so they register alongside it
    always_comb begin
        en_vdd_d = state_d != P_VDD;
        en_h_d   = !(state_d inside {P_VDD, P_EN});
        en_inp_d = !(state_d inside {P_VDD, P_EN, P_INP});
        rel_d    = state_d inside {RUN, U_HOLD, U_WR, U_REL};
        hold_d   = state_d inside {U_HOLD, U_WR, U_REL};
        ready_d  = state_d == RUN;
        por_d    = rel_d;
        err_d    = accept_o & ~pad_ok;
        tgt_d    = (accept_o && pad_ok) ? cfg_pad_i : tgt_q;
    end

    assign wr_o        = state_q == U_WR;
    assign rel_nx_o    = rel_d;
    assign hold_nx_o   = hold_d;
    assign tgt_nx_o    = tgt_d;
    assign en_vdd_o    = en_vdd_q;
    assign en_h_o      = en_h_q;
    assign en_inp_o    = en_inp_q;
    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;
    assign por_done_o  = por_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: power-on sequencer and runtime config controller for the
// 36-pad GPIO ring. Holds per-pad shadow registers and packs the per-pad
// 16-bit tech-config words.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   cfg            pad_cfg_ctrl_if.slave update channel
//   por_done_o     power-on sequence complete
//   pad_cfg_o      NumPads x 16 config words, pad p at [p*16 +: 16]
//   rb_pad_i, rb_data_o   readback (only when PADCFG_READBACK_EN is defined)
// Every output bit comes straight from a flop.
module pad_cfg_ctrl
    import zerosoc_pad_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    pad_cfg_ctrl_if.slave           cfg,
    output logic                    por_done_o,
    output logic [NumPads*CfgW-1:0] pad_cfg_o
`ifdef PADCFG_READBACK_EN
    ,
    input  logic [PadIdxW-1:0]      rb_pad_i,
    output logic [CfgW-1:0]         rb_data_o
`endif
);

    logic               accept, wr, rel_nx, hold_nx;
    logic [PadIdxW-1:0] tgt_nx;
    logic               en_vdd, en_h, en_inp;

    logic [2:0] cap_dm_q, cap_dm_d;
    logic       cap_slow_q, cap_slow_d, cap_vtrip_q, cap_vtrip_d;

    logic [NumPads-1:0][2:0] dm_q, dm_d;
    logic [NumPads-1:0]      slow_q, slow_d, vtrip_q, vtrip_d, hld_n_q, hld_n_d;
    logic [NumPads-1:0][CfgW-1:0] pad_word;

    pad_cfg_seq u_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_valid_i (cfg.cfg_valid_i),
        .cfg_pad_i   (cfg.cfg_pad_i),
        .accept_o    (accept),
        .wr_o        (wr),
        .rel_nx_o    (rel_nx),
        .hold_nx_o   (hold_nx),
        .tgt_nx_o    (tgt_nx),
        .en_vdd_o    (en_vdd),
        .en_h_o      (en_h),
        .en_inp_o    (en_inp),
        .cfg_ready_o (cfg.cfg_ready_o),
        .cfg_err_o   (cfg.cfg_err_o),
        .por_done_o  (por_done_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_dm_q    <= DefaultDm;
            cap_slow_q  <= 1'b0;
            cap_vtrip_q <= 1'b0;
            dm_q        <= {NumPads{DefaultDm}};
            slow_q      <= '0;
            vtrip_q     <= '0;
            hld_n_q     <= '0;
        end else begin
            cap_dm_q    <= cap_dm_d;
            cap_slow_q  <= cap_slow_d;
            cap_vtrip_q <= cap_vtrip_d;
            dm_q        <= dm_d;
            slow_q      <= slow_d;
            vtrip_q     <= vtrip_d;
            hld_n_q     <= hld_n_d;
        end
    end

    always_comb begin
        cap_dm_d    = accept ? cfg.cfg_dm_i    : cap_dm_q;
        cap_slow_d  = accept ? cfg.cfg_slow_i  : cap_slow_q;
        cap_vtrip_d = accept ? cfg.cfg_vtrip_i : cap_vtrip_q;
        dm_d    = dm_q;
        slow_d  = slow_q;
        vtrip_d = vtrip_q;
        for (int p = 0; p < NumPads; p++) begin
            // Only the update target drops hold; everyone else follows the ring-wide release.
            hld_n_d[p] = rel_nx & ~(hold_nx && tgt_nx == PadIdxW'(p));
            if (wr && tgt_nx == PadIdxW'(p)) begin
                dm_d[p]    = cap_dm_q;
                slow_d[p]  = cap_slow_q;
                vtrip_d[p] = cap_vtrip_q;
            end
        end
    end

    // Pure wiring of flops; ib_mode_sel, hld_ovr and analog_* are tied 0.
    always_comb begin
        for (int p = 0; p < NumPads; p++) begin
            pad_word[p]                 = '0;
            pad_word[p][BitHldHN]       = hld_n_q[p];
            pad_word[p][BitEnH]         = en_h;
            pad_word[p][BitEnInpH]      = en_inp;
            pad_word[p][BitEnVddaH]     = en_vdd;
            pad_word[p][BitEnVswitchH]  = en_vdd;
            pad_word[p][BitEnVddio]     = en_vdd;
            pad_word[p][BitVtripSel]    = vtrip_q[p];
            pad_word[p][BitSlow]        = slow_q[p];
            pad_word[p][BitDmLo +: 3]   = dm_q[p];
        end
    end

    assign pad_cfg_o = pad_word;

`ifdef PADCFG_READBACK_EN
    logic [CfgW-1:0] rb_data_q, rb_data_d;

    always_comb begin
        rb_data_d = (rb_pad_i < PadIdxW'(NumPads)) ? pad_word[rb_pad_i] : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rb_data_q <= '0;
        else       rb_data_q <= rb_data_d;
    end

    assign rb_data_o = rb_data_q;
`endif

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Self-checking bench for pad_cfg_ctrl: power-on timing, table-driven
// updates with a scoreboard, held-valid, bad-index, reset mid-write and
// (with PADCFG_READBACK_EN) readback.
module tb_pad_cfg_ctrl;
    import zerosoc_pad_pkg::*;

    localparam int NP = 36;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst;
    logic por_done;
    logic [NP*16-1:0] pad_cfg;

    always #5 clk = ~clk;

    pad_cfg_ctrl_if cfg_if();

`ifdef PADCFG_READBACK_EN
    logic [5:0]  rb_pad;
    logic [15:0] rb_data;
`endif

    pad_cfg_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg        (cfg_if),
        .por_done_o (por_done),
        .pad_cfg_o  (pad_cfg)
`ifdef PADCFG_READBACK_EN
        ,
        .rb_pad_i   (rb_pad),
        .rb_data_o  (rb_data)
`endif
    );

    typedef struct {
        logic [5:0] pad;
        logic [2:0] dm;
        logic       slow;
        logic       vtrip;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [5:0]  pad;
        logic [15:0] word;
        logic        err;
    } exp_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [NP];
    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_pads(input string name);
        int bad;
        bad = -1;
        for (int p = 0; p < NP; p++)
            if (pad_cfg[p*16 +: 16] !== model[p]) bad = p;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: pad %0d got %h expected %h", name, bad, pad_cfg[bad*16 +: 16], model[bad]);
        end
    endtask

    task automatic set_all(input logic [15:0] w);
        for (int p = 0; p < NP; p++) model[p] = w;
    endtask

    // Expected common word in cycle k after reset release
    function automatic logic [15:0] por_word(input int k);
        if (k <= 16) return 16'hC000;
        if (k <= 32) return 16'hC038;
        if (k <= 48) return 16'hC03A;
        if (k <= 64) return 16'hC03E;
        return 16'hC03F;
    endfunction

    // Call right after rst falls; leaves the bench in cycle 65.
    task automatic por_seq();
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (c inside {15, 16, 31, 32, 47, 48, 63, 64}) begin
                set_all(por_word(c + 1));
                chk_pads($sformatf("por_word_c%0d", c + 1));
                chk($sformatf("por_done_c%0d", c + 1), por_done, (c == 64));
                chk($sformatf("ready_c%0d", c + 1), cfg_if.cfg_ready_o, (c == 64));
            end
        end
    endtask

    task automatic do_write(input vec_t v);
        exp_t e;
        logic [15:0] old, w;
        int n;
        e.pad  = v.pad;
        e.err  = v.exp_err;
        e.word = 16'h0;
        if (!v.exp_err) begin
            e.word = model[v.pad];
            e.word[15:13] = v.dm;
            e.word[8] = v.slow;
            e.word[7] = v.vtrip;
        end
        chk("ready_before", cfg_if.cfg_ready_o, 1);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_pad_i   = v.pad;
        cfg_if.cfg_dm_i    = v.dm;
        cfg_if.cfg_slow_i  = v.slow;
        cfg_if.cfg_vtrip_i = v.vtrip;
        sb.push_back(e);
        tick();                              // handshake edge t; now cycle t+1
        cfg_if.cfg_valid_i = 1'b0;
        chk($sformatf("err_pad%0d", v.pad), cfg_if.cfg_err_o, v.exp_err);
        if (v.exp_err) begin
            e = sb.pop_front();
            chk("ready_on_err", cfg_if.cfg_ready_o, 1);
            chk_pads("pads_on_err");
            tick();
            chk("err_one_cycle", cfg_if.cfg_err_o, 0);
        end else begin
            chk("ready_drop", cfg_if.cfg_ready_o, 0);
            old = model[v.pad];
            n = 1;
            while (!cfg_if.cfg_ready_o && n < 30) begin
                w = (n >= H + 2) ? e.word : old;
                w[0] = 1'b0;
                model[v.pad] = w;
                chk_pads($sformatf("hold_pad%0d_t%0d", v.pad, n));
                tick();
                n++;
            end
            chk($sformatf("ready_return_pad%0d", v.pad), n, 2 * H + 2);
            e = sb.pop_front();
            model[e.pad] = e.word;
            chk_pads($sformatf("done_pad%0d", e.pad));
        end
    endtask

    vec_t vecs [8];
    vec_t v;

    initial begin
        vecs[0] = '{pad: 6'd20, dm: 3'b011, slow: 1'b1, vtrip: 1'b0, exp_err: 1'b0};
        vecs[1] = '{pad: 6'd0,  dm: 3'b001, slow: 1'b0, vtrip: 1'b1, exp_err: 1'b0};
        vecs[2] = '{pad: 6'd35, dm: 3'b111, slow: 1'b1, vtrip: 1'b1, exp_err: 1'b0};
        vecs[3] = '{pad: 6'd8,  dm: 3'b001, slow: 1'b0, vtrip: 1'b0, exp_err: 1'b0};
        vecs[4] = '{pad: 6'd40, dm: 3'b101, slow: 1'b1, vtrip: 1'b1, exp_err: 1'b1};
        vecs[5] = '{pad: 6'd9,  dm: 3'b000, slow: 1'b0, vtrip: 1'b0, exp_err: 1'b0};
        vecs[6] = '{pad: 6'd63, dm: 3'b010, slow: 1'b0, vtrip: 1'b1, exp_err: 1'b1};
        vecs[7] = '{pad: 6'd20, dm: 3'b101, slow: 1'b0, vtrip: 1'b1, exp_err: 1'b0};

        rst = 1'b1;
`ifdef PADCFG_READBACK_EN
        rb_pad = 6'd0;
`endif
        // Request held from reset onwards: must not be taken before RUN.
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_pad_i   = 6'd5;
        cfg_if.cfg_dm_i    = 3'b010;
        cfg_if.cfg_slow_i  = 1'b0;
        cfg_if.cfg_vtrip_i = 1'b1;
        repeat (3) tick();
        set_all(16'hC000);
        chk_pads("reset_pads");
        chk("reset_ready", cfg_if.cfg_ready_o, 0);
        chk("reset_por", por_done, 0);
        chk("reset_err", cfg_if.cfg_err_o, 0);

        rst = 1'b0;
        por_seq();

        // Cycle 65: handshake on pad 5, then retarget to pad 6 while frozen.
        tick();
        model[5][0] = 1'b0;
        chk_pads("held_accept_pad5");
        chk("held_ready_drop", cfg_if.cfg_ready_o, 0);
        cfg_if.cfg_pad_i = 6'd6;
        cfg_if.cfg_dm_i  = 3'b100;
        cfg_if.cfg_vtrip_i = 1'b0;
        for (int n = 2; n <= 2 * H + 2; n++) begin
            tick();
            if (n == H + 2) begin
                model[5][15:13] = 3'b010;
                model[5][7] = 1'b1;
            end
            if (n == 2 * H + 2) model[5][0] = 1'b1;
            chk_pads($sformatf("held_busy_t%0d", n));
        end
        chk("held_ready_back", cfg_if.cfg_ready_o, 1);
        tick();                              // pad 6 accepted on the first RUN cycle
        cfg_if.cfg_valid_i = 1'b0;
        model[6][0] = 1'b0;
        chk_pads("held_accept_pad6");
        for (int n = 2; n <= 2 * H + 2; n++) tick();
        model[6][15:13] = 3'b100;
        model[6][0] = 1'b1;
        chk_pads("held_done_pad6");
        chk("held_ready_final", cfg_if.cfg_ready_o, 1);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            do_write(v);
        end
        chk("sb_empty", sb.size(), 0);

`ifdef PADCFG_READBACK_EN
        rb_pad = 6'd8;
        tick();
        chk("rb_pad8_dm", rb_data[15:13], 3'b001);
        chk("rb_pad8_word", rb_data, model[8]);
        rb_pad = 6'd40;
        tick();
        chk("rb_invalid", rb_data, 0);
`endif

        // Reset in the middle of U_WR on pad 3
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_pad_i   = 6'd3;
        cfg_if.cfg_dm_i    = 3'b001;
        tick();
        cfg_if.cfg_valid_i = 1'b0;
        repeat (4) tick();                   // cycle t+5: the write cycle
        #2 rst = 1'b1;
        #1;
        set_all(16'hC000);
        chk_pads("midwr_reset_pads");
        chk("midwr_reset_ready", cfg_if.cfg_ready_o, 0);
        chk("midwr_reset_por", por_done, 0);
        tick();
        tick();
        rst = 1'b0;
        por_seq();

        v = '{pad: 6'd3, dm: 3'b011, slow: 1'b1, vtrip: 1'b0, exp_err: 1'b0};
        do_write(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pad_cfg_ctrl.md
# pad_cfg_ctrl

Power-on sequencer and runtime configuration controller for the 36-pad GPIO ring (west, north, east, south; 9 pads each). It replaces static tech-config tie-offs. After reset it ramps the pad enable controls in a fixed order and releases hold. It then accepts single-pad drive-mode/slew/trip updates, applying each one glitch-free by freezing that pad with its hold control. It sits in the core between the SoC register interface and the four per-side tech-config buses.

## Interface
- NumPads, 36, number of pads; pad p maps to side p/9 (0=we, 1=no, 2=ea, 3=so), slot p%9.
- RampCycles, 16, cycles spent in each power-on step (≥1).
- HoldCycles, 4, cycles a pad is held frozen before and after a config write (≥1).
- DefaultDm, 3'b110, reset drive mode (strong pull-up/pull-down).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- cfg_valid_i  in  1  update request.
- cfg_ready_o  out  1  update accepted when valid&ready.
- cfg_pad_i  in  6  target pad index.
- cfg_dm_i  in  3  new drive mode.
- cfg_slow_i  in  1  new slow-slew bit.
- cfg_vtrip_i  in  1  new vtrip_sel bit.
- cfg_err_o  out  1  one-cycle pulse: accepted index ≥ NumPads.
- por_done_o  out  1  power-on sequence complete.
- pad_cfg_o  out  NumPads*16  per-pad bits [15:0]: 0 hld_h_n, 1 enable_h, 2 enable_inp_h, 3 enable_vdda_h, 4 enable_vswitch_h, 5 enable_vddio, 6 ib_mode_sel, 7 vtrip_sel, 8 slow, 9 hld_ovr, 10–12 analog_en/sel/pol, 15:13 dm.

## Operation
- Reset values: all hld_h_n, enable_* = 0; dm = DefaultDm; vtrip, slow, ib_mode_sel, hld_ovr, analog_* = 0; cfg_ready_o = 0; cfg_err_o = 0; por_done_o = 0; FSM = P_VDD.
- Power-on FSM, shared across all pads:
  - P_VDD: after RampCycles, set enable_vdda_h, enable_vswitch_h, enable_vddio.
  - P_EN: after RampCycles, set enable_h.
  - P_INP: after RampCycles, set enable_inp_h.
  - P_REL: after RampCycles, set hld_h_n on every pad and go to RUN.
- RUN: cfg_ready_o = 1 and por_done_o = 1. ib_mode_sel, hld_ovr and analog_* remain 0 permanently.
- Update sequence:
  - Accept: capture pad, dm, slow, vtrip; cfg_ready_o drops the next cycle.
  - U_HOLD: target pad's hld_h_n = 0 for HoldCycles.
  - U_WR: one cycle; write the target's dm/slow/vtrip.
  - U_REL: HoldCycles more with hld_h_n still 0, then restore hld_h_n = 1 and return to RUN.
  - Other pads are untouched throughout.
- Invalid index (≥ NumPads): accepted, cfg_err_o pulses the cycle after the handshake, no pad changes, FSM stays in RUN; ready stays 1.
- cfg_valid_i is ignored outside RUN; requests are not queued.
- Reset at any point: immediately restore reset values; the power-on sequence restarts after release.

## Timing
- Counter: $clog2(max(RampCycles,HoldCycles)+1) bits; counts 0..N-1; the transition fires on the edge where count == N-1, and count clears on every state change.
- First rising edge after rst_i falls is cycle 1. Step outputs change at the end of cycles RampCycles, 2·RampCycles, 3·RampCycles and 4·RampCycles. por_done_o and cfg_ready_o are high from cycle 4·RampCycles+1.
- Valid update handshake at cycle t:
  - Target hld_h_n = 0 at t+1.
  - New dm/slow/vtrip visible at t+HoldCycles+2.
  - hld_h_n = 1 and cfg_ready_o = 1 at t+2·HoldCycles+2.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- PADCFG_READBACK_EN defined: adds a readback interface.
  - Ports: rb_pad_i in 6, rb_data_o out 16.
  - rb_data_o is the registered pad_cfg_o slice for rb_pad_i, with 1-cycle latency; it reads 0 for an invalid index.
- PADCFG_READBACK_EN undefined: the readback ports are absent, and the other outputs are cycle-identical to the defined build.

## Structure
- zerosoc_pad_pkg:
  - Bit-offset localparams for the 16 config fields.
  - Power-on/update state enum: P_VDD, P_EN, P_INP, P_REL, RUN, U_HOLD, U_WR, U_REL.
  - Side/slot index functions.
- Sub-module pad_cfg_seq: the shared FSM and counter; outputs global enables, a hold-target index and a write strobe. pad_cfg_ctrl holds the per-pad shadow registers and does output packing.

## Test plan
- Reset release, RampCycles=16: enable_vdda_h rises after cycle 16, enable_h after 32, enable_inp_h after 48, all hld_h_n after 64; por_done_o=1 at cycle 65.
- Pad 20, dm=3'b011, slow=1 at t, HoldCycles=4: pad 20 hld_h_n=0 at t+1; dm=3'b011 at t+6; hld_h_n=1 and cfg_ready_o=1 at t+10; pads ≠20 are unchanged throughout.
- cfg_pad_i=40: cfg_err_o pulses at t+1; pad_cfg_o unchanged; cfg_ready_o stays 1.
- cfg_valid_i held during power-on and during U_HOLD: no acceptance; the request is accepted on the first RUN cycle.
- rst_i asserted mid-U_WR: outputs return to reset values immediately, dm=3'b110; por_done_o reasserts 64 cycles after release.
- With PADCFG_READBACK_EN: after writing pad 8 dm=3'b001, rb_pad_i=8 gives rb_data_o[15:13]=3'b001 one cycle later.
